// File: rtl/pc_unit.sv
// Fetch-stage program counter with redirect, stall hold and a circular return-address stack.
// Optional misaligned-redirect trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter int unsigned     INC          = 4,
  parameter int unsigned     RAS_DEPTH    = 4,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0010)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               stall,
  input  logic                               redirect_valid,
  input  logic [XLEN-1:0]                    redirect_target,
  input  logic                               call,
  input  logic                               ret,
  output logic [XLEN-1:0]                    pc,
  output logic [XLEN-1:0]                    pc_next,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
  output logic                               ras_overflow,
  output logic                               ras_underflow,
  output logic                               misalign_trap
);

  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PtrW = $clog2(RAS_DEPTH);

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PtrW-1:0] top_q, top_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            trap_q, trap_d;

  logic [XLEN-1:0] ras_q [RAS_DEPTH];

  logic [XLEN-1:0] seq_pc;
  logic [PtrW-1:0] top_inc;
  logic [PtrW-1:0] top_dec;
  logic            push;
  logic            replace;
  logic            misaligned;
  logic [PtrW-1:0] wr_idx;

  assign seq_pc     = pc_q + XLEN'(INC);
  assign top_inc    = (top_q == PtrW'(RAS_DEPTH - 1)) ? '0 : top_q + PtrW'(1);
  assign top_dec    = (top_q == '0) ? PtrW'(RAS_DEPTH - 1) : top_q - PtrW'(1);
  assign misaligned = TrapEn && (redirect_target[1:0] != 2'b00);

  // Next-state selection in priority order: reset > redirect > stall > ret > sequential.
  always_comb begin
    pc_d    = pc_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    trap_d  = 1'b0;
    push    = 1'b0;
    replace = 1'b0;

    if (reset) begin
      pc_d  = RESET_VECTOR;
      top_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else if (redirect_valid) begin
      pc_d   = misaligned ? TRAP_VECTOR : redirect_target;
      trap_d = misaligned;
      push   = call;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (ret) begin
      if (cnt_q != '0) begin
        pc_d = ras_q[top_q];
        if (call) begin
          replace = 1'b1;
        end else begin
          top_d = top_dec;
          cnt_d = cnt_q - CntW'(1);
        end
      end else begin
        pc_d  = seq_pc;
        udf_d = 1'b1;
        push  = call;
      end
    end else begin
      pc_d = seq_pc;
      push = call;
    end

    // A push on a full stack wraps onto the oldest entry.
    if (push) begin
      top_d = top_inc;
      if (cnt_q == CntW'(RAS_DEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    pc_q   <= pc_d;
    top_q  <= top_d;
    cnt_q  <= cnt_d;
    ovf_q  <= ovf_d;
    udf_q  <= udf_d;
    trap_q <= trap_d;
  end

  assign wr_idx = push ? top_inc : top_q;

  // Stack storage needs no reset; entries beyond the count are never read.
  always_ff @(posedge clk) begin
    if (push || replace) begin
      ras_q[wr_idx] <= seq_pc;
    end
  end

  assign pc            = pc_q;
  assign pc_next       = pc_d;
  assign ras_count     = cnt_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = udf_q;
  assign misalign_trap = trap_q;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the RISC core fetch stage; successor to the plain PC register.
- Adds reset vector, configurable increment, stall hold, branch/jump redirect and a small return-address stack (RAS) for call/return prediction.
- Feeds the instruction-memory address; driven by hazard unit (stall) and execute stage (redirect, call, ret).

Parameters:
- XLEN, 32, PC and address width in bits.
- RESET_VECTOR, 32'h00000000, PC value loaded on reset.
- INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, return-address stack entries (>=2).
- TRAP_VECTOR, 32'h00000010, misaligned-redirect target; used only when PC_MISALIGN_TRAP_EN is defined.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC; suppresses call/ret.
- redirect_valid  input  1  load redirect_target this cycle.
- redirect_target  input  XLEN  branch/jump target.
- call  input  1  push return address (pc+INC).
- ret  input  1  pop RAS and jump to popped address.
- pc  output  XLEN  current PC (registered).
- pc_next  output  XLEN  combinational value pc takes on the next edge.
- ras_count  output  $clog2(RAS_DEPTH+1)  valid RAS entries.
- ras_overflow  output  1  sticky: a push overwrote the oldest entry.
- ras_underflow  output  1  sticky: ret issued with empty RAS.
- misalign_trap  output  1  registered one-cycle pulse (macro only; else 0).

Behaviour:
- Reset (synchronous, active-high, on rising clk edge): pc=RESET_VECTOR, ras_count=0, ras_overflow=0, ras_underflow=0, misalign_trap=0; RAS storage contents don't care. Reset asserted mid-operation overrides all other inputs that cycle.
- Latency: every update visible on pc one cycle after the inputs are sampled; pc_next always equals the value loaded at the next edge.
- Priority, highest first: reset > redirect_valid > stall > ret > sequential.
- redirect_valid=1: pc=redirect_target, stall ignored. If call=1 in the same cycle, push pc+INC. ret ignored (no pop, no underflow).
- stall=1 (no redirect): pc holds; call and ret ignored; RAS and flags unchanged.
- ret=1, ras_count>0: pc=top entry; pop (count-1).
- ret=1, ras_count==0: pc=pc+INC; ras_underflow set (sticky until reset).
- call=1 with ret=1, not stalled, no redirect, count>0: pc=old top; top entry replaced by pc+INC; count unchanged. With count==0: treat as underflow ret plus a push.
- Otherwise: pc=pc+INC; if call=1 push pc+INC.
- Push when ras_count==RAS_DEPTH: circular buffer, oldest entry overwritten, count stays RAS_DEPTH, ras_overflow set (sticky).
- Arithmetic: pc+INC modulo 2^XLEN; 32'hFFFFFFFC+4 wraps to 0 with no flag.
- RAS implemented as circular array with top pointer modulo RAS_DEPTH.

Optional Feature:
- Macro PC_MISALIGN_TRAP_EN.
- Defined: on accepted redirect with redirect_target[1:0]!=0, pc=TRAP_VECTOR instead of redirect_target, misalign_trap=1 for exactly the next cycle; any call push in that cycle still occurs. Misaligned ret targets are not checked.
- Not defined: redirect_target loaded unmodified; misalign_trap tied to 0; TRAP_VECTOR unused.

Test Plan:
- Reset 1 cycle, then 3 free-running cycles -> pc 0,4,8,12; flags 0; ras_count 0.
- Redirect to 32'hFFFFFFF8 with stall=1, then two sequential cycles -> pc FFFFFFF8, FFFFFFFC, then 00000000 (wrap).
- At pc=0x100: call+redirect to 0x400; 2 sequential cycles; ret -> pc 0x400,0x404,0x408 then 0x104; ras_count 1 then 0.
- 5 calls with RAS_DEPTH=4 at pcs 0x0,0x10,0x20,0x30,0x40 (redirects) -> ras_overflow=1, count 4; 4 rets return 0x44,0x34,0x24,0x14; 5th ret -> pc+4, ras_underflow=1.
- Stall=1 with call=1 and ret=1 -> pc held, ras_count unchanged; reset asserted mid-sequence -> pc=RESET_VECTOR, count 0, flags cleared next cycle.
- With PC_MISALIGN_TRAP_EN: redirect to 0x202 -> pc=0x10, misalign_trap high exactly one cycle; without macro -> pc=0x202, misalign_trap 0.
